preset_down_timer: RTL

Loadable down-counting interval timer, the decrement-side counterpart of the team's preset/clear up counter. A preset pulse loads a start value and arms the timer. The timer then counts down on enabled cycles and flags terminal count. It runs either one-shot or auto-reload, and serves as the cycle-interval/timeout source for sequential blocks in this area.

---
 rtl/preset_down_timer_pkg.sv | 20 ++
 rtl/preset_down_timer.sv | 107 ++++++++++
 2 files changed

// File: rtl/preset_down_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : preset_down_timer_pkg
//  Purpose  : Shared constants and types for the preset down timer.
//             - DEFAULT_WIDTH : default count / load-value width
//             - state_t       : timer state (IDLE, RUN, DONE), 2-bit encoded
//  Revision : 1.0  initial release
// ============================================================================
package preset_down_timer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : preset_down_timer_pkg
`default_nettype wire

// File: rtl/preset_down_timer.sv
`default_nettype none
// ============================================================================
//  Module   : preset_down_timer
//  Purpose  : Loadable down-counting interval timer with one-shot and
//             auto-reload modes. A preset loads a start value and arms the
//             timer; enabled cycles decrement the count and the terminal
//             edge raises a one-cycle tc pulse.
//  Ports    :
//    clk    in   clock, all state updates on the rising edge
//    clr    in   synchronous active-high reset (highest priority)
//    pr     in   preset: load n and arm (n = 0 goes straight to DONE)
//    n      in   load value, sampled only when pr is high
//    en     in   count enable
//    reload in   1 = auto-reload from the captured load value, 0 = one-shot
//    a      out  current count (registered)
//    tc     out  terminal-count pulse (registered, one cycle)
//    busy   out  high while in RUN (registered)
//    done   out  high while in DONE (registered)
//  Revision : 1.0  initial release
// ============================================================================
module preset_down_timer
    import preset_down_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pr,
    input  logic [WIDTH-1:0] n,
    input  logic             en,
    input  logic             reload,
    output logic [WIDTH-1:0] a,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           st_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] rl_q;
    logic             tc_q;
    logic             busy_q;
    logic             done_q;

    // busy/done are registered alongside st_q so they never depend on
    // inputs combinationally.
    always_ff @(posedge clk) begin
        if (clr) begin
            st_q   <= ST_IDLE;
            a_q    <= C_ZERO;
            rl_q   <= C_ZERO;
            tc_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (pr) begin
            tc_q <= 1'b0;
            a_q  <= n;
            rl_q <= n;
            if (n != C_ZERO) begin
                st_q   <= ST_RUN;
                busy_q <= 1'b1;
                done_q <= 1'b0;
            end else begin
                // A zero load expires immediately, silently (no tc).
                st_q   <= ST_DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end else begin
            tc_q <= 1'b0;
            case (st_q)
                ST_RUN: begin
                    if (en) begin
                        if (a_q == C_ONE) begin
                            tc_q <= 1'b1;
                            if (reload) begin
                                // Reload from the captured value, never live n,
                                // so the count never shows 0 in this mode.
                                a_q <= rl_q;
                            end else begin
                                a_q    <= C_ZERO;
                                st_q   <= ST_DONE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end
                        end else begin
                            a_q <= a_q - C_ONE;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE hold; only pr or clr leave them.
                end
            endcase
        end
    end

    assign a    = a_q;
    assign tc   = tc_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule : preset_down_timer
`default_nettype wire
